imm_encoder: RTL

- Pipelined immediate encoder: the inverse of the core's immediate sign-extension/decode stage.
- Takes a 32-bit immediate, a format select using the same ImmSrc encoding as decode, the non-immediate instruction fields and an opcode. Emits a complete 32-bit RV32I instruction word.
- Used by the program loader / self-test sequencer to assemble instructions written into instruction memory.
- Valid/ready streaming on both sides, 2-stage pipeline, range checking of the immediate.

---
 rtl/imm_encoder_if.sv | 31 +++
 rtl/imm_encoder.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/imm_encoder_if.sv
// -----------------------------------------------------------------------------
// imm_encoder_if
// Streaming bundle for the immediate encoder.
//   Request side : in_valid, in_ready, in_imm[31:0], in_imm_src[1:0],
//                  in_base[24:0] (instr[31:7] template), in_opcode[6:0]
//   Result side  : out_valid, out_ready, out_instr[31:0], out_err
// modport master : the requester/consumer (loader, sequencer, testbench)
// modport slave  : the encoder itself
// -----------------------------------------------------------------------------
interface imm_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_imm;
  logic [1:0]  in_imm_src;
  logic [24:0] in_base;
  logic [6:0]  in_opcode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;

  modport master (
    output in_valid, in_imm, in_imm_src, in_base, in_opcode, out_ready,
    input  in_ready, out_valid, out_instr, out_err
  );

  modport slave (
    input  in_valid, in_imm, in_imm_src, in_base, in_opcode, out_ready,
    output in_ready, out_valid, out_instr, out_err
  );
endinterface

// File: rtl/imm_encoder.sv
// -----------------------------------------------------------------------------
// imm_encoder
// Two-stage pipelined RV32I immediate encoder: the inverse of the decode-stage
// immediate extraction. Scatters a 32-bit immediate into the I/S/B/J field
// positions of an instruction template and flags immediates that the selected
// format cannot represent.
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset, flushes both stages
//   bus        : imm_encoder_if.slave (valid/ready request and result streams)
//   err_count  : saturating count of unrepresentable requests
// Parameters:
//   STRICT     : 1 = unrepresentable requests are dropped (only counted)
//                0 = they are emitted with out_err=1 and a truncated encoding
//   CNT_W      : width of err_count
// -----------------------------------------------------------------------------
module imm_encoder #(
  parameter bit STRICT = 1'b0,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  imm_encoder_if.slave      bus,
  output logic [CNT_W-1:0]  err_count
);

  // ImmSrc encoding shared with the decode stage
  localparam logic [1:0] SRC_I = 2'b00;
  localparam logic [1:0] SRC_S = 2'b01;
  localparam logic [1:0] SRC_B = 2'b10;
  localparam logic [1:0] SRC_J = 2'b11;

  // ---------------------------------------------------------------------------
  // Encode (combinational, feeds stage 1)
  // ---------------------------------------------------------------------------
  logic [31:0] tmpl;
  logic [31:0] enc_instr_next;
  logic        enc_err_next;
  logic [30:11] sign_diff;

  assign tmpl = {bus.in_base, bus.in_opcode};

  // sign_diff[k] is set when imm[k] differs from imm[k+1]; a format whose
  // sign run starts at bit m is representable iff sign_diff[30:m] is all zero.
  genvar gi;
  generate
    for (gi = 11; gi <= 30; gi++) begin : g_sign_diff
      assign sign_diff[gi] = bus.in_imm[gi] ^ bus.in_imm[gi+1];
    end
  endgenerate

  always_comb begin
    enc_instr_next = tmpl;
    enc_err_next   = 1'b0;
    unique case (bus.in_imm_src)
      SRC_I: begin
        enc_instr_next[31:20] = bus.in_imm[11:0];
        enc_err_next          = |sign_diff[30:11];
      end
      SRC_S: begin
        enc_instr_next[31:25] = bus.in_imm[11:5];
        enc_instr_next[11:7]  = bus.in_imm[4:0];
        enc_err_next          = |sign_diff[30:11];
      end
      SRC_B: begin
        enc_instr_next[31]    = bus.in_imm[12];
        enc_instr_next[30:25] = bus.in_imm[10:5];
        enc_instr_next[11:8]  = bus.in_imm[4:1];
        enc_instr_next[7]     = bus.in_imm[11];
        enc_err_next          = (|sign_diff[30:12]) | bus.in_imm[0];
      end
      SRC_J: begin
        enc_instr_next[31]    = bus.in_imm[20];
        enc_instr_next[30:21] = bus.in_imm[10:1];
        enc_instr_next[20]    = bus.in_imm[11];
        enc_instr_next[19:12] = bus.in_imm[19:12];
        enc_err_next          = (|sign_diff[30:20]) | bus.in_imm[0];
      end
      default: begin
        enc_instr_next = tmpl;
        enc_err_next   = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Pipeline control
  // ---------------------------------------------------------------------------
  logic             s1_valid_reg;
  logic [31:0]      s1_instr_reg;
  logic             s1_err_reg;
  logic             s2_valid_reg;
  logic [31:0]      s2_instr_reg;
  logic             s2_err_reg;
  logic [CNT_W-1:0] err_count_reg;

  logic s2_adv;
  logic s1_adv;
  logic in_ready_int;
  logic s1_drop;

  assign s2_adv       = !s2_valid_reg || bus.out_ready;
  assign s1_adv       = s2_adv;
  // An empty S1 keeps accepting even while S2 is stalled (bubble collapse).
  assign in_ready_int = !s1_valid_reg || s2_adv;
  // In strict mode an errored word dies at the S1->S2 boundary.
  assign s1_drop      = STRICT && s1_err_reg;

  // Stage 1: encoded word + error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      s1_instr_reg <= '0;
      s1_err_reg   <= 1'b0;
    end else if (in_ready_int) begin
      s1_valid_reg <= bus.in_valid;
      if (bus.in_valid) begin
        s1_instr_reg <= enc_instr_next;
        s1_err_reg   <= enc_err_next;
      end
    end
  end

  // Stage 2: output register; payload holds while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_reg <= 1'b0;
      s2_instr_reg <= '0;
      s2_err_reg   <= 1'b0;
    end else if (s1_adv) begin
      s2_valid_reg <= s1_valid_reg && !s1_drop;
      if (s1_valid_reg && !s1_drop) begin
        s2_instr_reg <= s1_instr_reg;
        s2_err_reg   <= s1_err_reg;
      end
    end
  end

  // Error counter: counted as the word leaves S1, whether kept or dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count_reg <= '0;
    end else if (s1_adv && s1_valid_reg && s1_err_reg && (err_count_reg != '1)) begin
      err_count_reg <= err_count_reg + CNT_W'(1);
    end
  end

  assign bus.in_ready  = in_ready_int;
  assign bus.out_valid = s2_valid_reg;
  assign bus.out_instr = s2_instr_reg;
  assign bus.out_err   = s2_err_reg;
  assign err_count     = err_count_reg;

endmodule
